// File: rtl/adc_parallel_responder_if.sv
// ---------------------------------------------------------------------------
// adc_parallel_responder_if
// Parallel-bus ADC interface between an AD7606-style controller (master)
// and the converter or its responder model (slave).
//
// Signals:
//   convst   master->slave  conversion start, rising edge starts a conversion
//   cs_n     master->slave  chip select, active-low
//   rd_n     master->slave  read strobe, active-low
//   busy     slave->master  conversion in progress
//   db       slave->master  16-bit data bus, 0 when not driven
//   db_oe    slave->master  data bus driven
//   frstdata slave->master  high while channel 0 is on db
// ---------------------------------------------------------------------------
interface adc_parallel_responder_if;
  logic        convst;
  logic        cs_n;
  logic        rd_n;
  logic        busy;
  logic [15:0] db;
  logic        db_oe;
  logic        frstdata;

  modport master (
    output convst, cs_n, rd_n,
    input  busy, db, db_oe, frstdata
  );

  modport slave (
    input  convst, cs_n, rd_n,
    output busy, db, db_oe, frstdata
  );
endinterface

// File: rtl/adc_parallel_responder.sv
// ---------------------------------------------------------------------------
// adc_parallel_responder
// Device end of an AD7606-style CS#/RD# parallel read interface. A rising
// edge on convst starts a conversion that holds busy for CONV_CYCLES clocks;
// afterwards each RD# strobe (with CS# low) serves the next 16-bit channel
// word, channel 0..NUM_CH-1 in turn. The word for channel k is
// {k[2:0], conv_cnt[12:0]}, so a bench can tell channel and conversion apart.
//
// Parameters:
//   NUM_CH       channels served per conversion (1..8)
//   CONV_CYCLES  clk cycles busy stays high per conversion (>=2)
//
// Ports:
//   clk   system clock, all inputs synchronous to it
//   rst   synchronous reset, active-high
//   bus   slave side of adc_parallel_responder_if (convst, cs_n, rd_n in;
//         busy, db, db_oe, frstdata out)
// ---------------------------------------------------------------------------
module adc_parallel_responder #(
  parameter int NUM_CH      = 8,
  parameter int CONV_CYCLES = 200
) (
  input  logic                      clk,
  input  logic                      rst,
  adc_parallel_responder_if.slave   bus
);

  localparam int         TW      = $clog2(CONV_CYCLES);
  localparam logic [2:0] LAST_CH = 3'(NUM_CH - 1);

  typedef enum logic {
    IDLE,
    CONV
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic            busy_q;
  logic [TW-1:0]   timer_q;
  logic [12:0]     conv_cnt_q;
  logic [2:0]      ch_ptr_q;
  logic            convst_q;
  logic            rd_q;
  logic            cs_q;

  logic            conv_edge;
  logic            rd_end;
  logic            conv_done;

  logic            rd_active;
  logic [15:0]     db_d;
  logic            db_oe_d;
  logic            frstdata_d;

  // A read completes on the rising edge of rd_n, but only if the chip was
  // selected while the strobe was low.
  assign conv_edge = bus.convst & ~convst_q;
  assign rd_end    = bus.rd_n & ~rd_q & ~cs_q;
  assign conv_done = (state_q == CONV) && (timer_q == '0);

  // State register. busy is registered from the next state so it rises
  // the cycle after the convst edge and falls the cycle after completion.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == CONV);
    end
  end

  // Next-state logic. An edge during CONV (including the completion
  // cycle) is ignored: conversions never restart.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch forms.
    state_d = state_q;
    case (state_q)
      IDLE:    if (conv_edge) state_d = CONV;
      CONV:    if (conv_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: conversion timer, conversion counter, channel pointer and
  // the registered copies used for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q    <= '0;
      conv_cnt_q <= '0;
      ch_ptr_q   <= '0;
      convst_q   <= 1'b0;
      rd_q       <= 1'b1;
      cs_q       <= 1'b1;
    end else begin
      convst_q <= bus.convst;
      rd_q     <= bus.rd_n;
      cs_q     <= bus.cs_n;

      if (state_q == IDLE && conv_edge)
        timer_q <= TW'(CONV_CYCLES - 1);
      else if (state_q == CONV && !conv_done)
        timer_q <= timer_q - TW'(1);

      // Completion outranks a simultaneous read end: the new conversion
      // is always served from channel 0.
      if (conv_done) begin
        conv_cnt_q <= conv_cnt_q + 13'd1;
        ch_ptr_q   <= '0;
      end else if (rd_end) begin
        ch_ptr_q <= (ch_ptr_q == LAST_CH) ? 3'd0 : ch_ptr_q + 3'd1;
      end
    end
  end

  // Read path, combinational from registered state so data is on the bus
  // in the same cycle RD# goes low. Gated by rst so the bus is quiet in
  // reset even before the first reset edge.
  always_comb begin
    rd_active  = ~bus.cs_n & ~bus.rd_n & ~rst;
    db_d       = 16'd0;
    db_oe_d    = 1'b0;
    frstdata_d = 1'b0;
    if (rd_active) begin
      db_d       = {ch_ptr_q, conv_cnt_q};
      db_oe_d    = 1'b1;
      frstdata_d = (ch_ptr_q == 3'd0);
    end
  end

  assign bus.busy     = busy_q;
  assign bus.db       = db_d;
  assign bus.db_oe    = db_oe_d;
  assign bus.frstdata = frstdata_d;

endmodule

// File: tb/tb_adc_parallel_responder.sv
// ---------------------------------------------------------------------------
// tb_adc_parallel_responder
// Directed bench for adc_parallel_responder (NUM_CH=8, CONV_CYCLES=4).
// A behavioural model (remaining busy cycles, conversion number, next
// channel) predicts every output; a negedge process compares the DUT to it
// each cycle. Directed sequences add literal expectations that pin the
// model to the hand-computed values.
// ---------------------------------------------------------------------------
module tb_adc_parallel_responder;

  localparam int NUM_CH      = 8;
  localparam int CONV_CYCLES = 4;

  logic clk;
  logic rst;

  adc_parallel_responder_if bus ();

  adc_parallel_responder #(
    .NUM_CH      (NUM_CH),
    .CONV_CYCLES (CONV_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int   m_busy_left = 0;   // busy cycles still to come
  int   m_conv      = 0;   // completed conversions, mod 8192
  int   m_ch        = 0;   // channel served by the next read
  logic p_convst    = 1'b0;
  logic p_rd_n      = 1'b1;
  logic p_cs_n      = 1'b1;

  always @(posedge clk) begin
    if (rst) begin
      m_busy_left <= 0;
      m_conv      <= 0;
      m_ch        <= 0;
      p_convst    <= 1'b0;
      p_rd_n      <= 1'b1;
      p_cs_n      <= 1'b1;
    end else begin
      p_convst <= bus.convst;
      p_rd_n   <= bus.rd_n;
      p_cs_n   <= bus.cs_n;
      if (m_busy_left == 1) begin
        m_conv      <= (m_conv + 1) % 8192;
        m_ch        <= 0;
        m_busy_left <= 0;
      end else begin
        if (m_busy_left > 1)
          m_busy_left <= m_busy_left - 1;
        else if (bus.convst && !p_convst)
          m_busy_left <= CONV_CYCLES;
        if (bus.rd_n && !p_rd_n && !p_cs_n)
          m_ch <= (m_ch + 1) % NUM_CH;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic        e_oe;
    logic [15:0] e_db;
    logic [15:0] ch16;
    logic [15:0] cv16;
    e_oe = !bus.cs_n && !bus.rd_n && !rst;
    ch16 = 16'(m_ch);
    cv16 = 16'(m_conv);
    e_db = e_oe ? {ch16[2:0], cv16[12:0]} : 16'd0;
    check("cmp_busy",     16'(bus.busy),     16'(m_busy_left > 0));
    check("cmp_db",       bus.db,            e_db);
    check("cmp_db_oe",    16'(bus.db_oe),    16'(e_oe));
    check("cmp_frstdata", 16'(bus.frstdata), 16'(e_oe && m_ch == 0));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One read: rd_n low one cycle, high one cycle, cs_n held low.
  task automatic do_read(input string name, input logic [15:0] exp_db,
                         input logic exp_f);
    bus.cs_n = 1'b0;
    bus.rd_n = 1'b0;
    @(negedge clk);
    check({name, "_db"}, bus.db, exp_db);
    check({name, "_f"}, 16'(bus.frstdata), 16'(exp_f));
    tick();
    bus.rd_n = 1'b1;
    tick();
  endtask

  // convst high for one cycle; returns in busy cycle 1.
  task automatic pulse_conv();
    bus.convst = 1'b1;
    tick();
    bus.convst = 1'b0;
  endtask

  task automatic expect_busy(input string name, input logic exp);
    @(negedge clk);
    check(name, 16'(bus.busy), 16'(exp));
  endtask

  initial begin
    logic [15:0] w;
    rst        = 1'b1;
    bus.convst = 1'b0;
    bus.cs_n   = 1'b1;
    bus.rd_n   = 1'b1;
    tick(2);
    rst = 1'b0;
    expect_busy("reset_busy", 1'b0);
    check("reset_db_oe", 16'(bus.db_oe), 16'd0);

    // 1: busy high exactly 4 cycles.
    pulse_conv();
    for (int i = 0; i < 4; i++) begin
      expect_busy("t1_busy_hi", 1'b1);
      tick();
    end
    expect_busy("t1_busy_lo", 1'b0);

    // 2: eight channels of conversion 1, then wrap to ch0.
    for (int i = 0; i < 8; i++) begin
      w = 16'(i);
      do_read("t2_read", {w[2:0], 13'd1}, i == 0);
    end
    do_read("t2_wrap", 16'h0001, 1'b1);
    bus.cs_n = 1'b1;
    tick();

    // 3: second edge in busy cycle 2 is ignored.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pulse_conv();
    tick();
    bus.convst = 1'b1;
    tick();
    bus.convst = 1'b0;
    expect_busy("t3_busy_c3", 1'b1);
    tick();
    expect_busy("t3_busy_c4", 1'b1);
    tick();
    expect_busy("t3_busy_lo", 1'b0);
    tick(2);
    do_read("t3_ch0", 16'h0001, 1'b1);

    // 4: read ch1, start conv 2, read ch2 during busy.
    do_read("t4_ch1", 16'h2001, 1'b0);
    pulse_conv();
    do_read("t4_busy_read", 16'h4001, 1'b0);
    tick(3);
    expect_busy("t4_done", 1'b0);

    // 5: rd_n pulse with cs_n high neither drives nor advances.
    bus.cs_n = 1'b1;
    bus.rd_n = 1'b0;
    @(negedge clk);
    check("t5_db", bus.db, 16'd0);
    check("t5_db_oe", 16'(bus.db_oe), 16'd0);
    tick();
    bus.rd_n = 1'b1;
    tick();
    do_read("t4_after_done", 16'h0002, 1'b1);

    // 7: read ends in the completion cycle; completion wins, ch_ptr=0.
    pulse_conv();
    tick(2);
    bus.rd_n = 1'b0;
    @(negedge clk);
    check("t7_busy_read", bus.db, 16'h2002);
    tick();
    bus.rd_n = 1'b1;
    tick();
    expect_busy("t7_done", 1'b0);
    do_read("t7_ch0", 16'h0003, 1'b1);

    // 6: reset at busy cycle 3 aborts and clears conv_cnt.
    pulse_conv();
    tick(2);
    rst      = 1'b1;
    bus.cs_n = 1'b0;
    bus.rd_n = 1'b0;
    @(negedge clk);
    check("t6_oe_in_rst", 16'(bus.db_oe), 16'd0);
    tick();
    bus.rd_n = 1'b1;
    rst      = 1'b0;
    expect_busy("t6_busy", 1'b0);
    tick();
    do_read("t6_read", 16'h0000, 1'b1);
    bus.cs_n = 1'b1;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
